// File: rtl/line_buffer_ctrl.sv
// Line-buffer controller: rotates row writes across KERNEL_SIZE+1 line BRAMs and
// issues a shared read whose tag is delayed to line up with the BRAM output data.
module line_buffer_ctrl #(
    parameter int HRES        = 1280,
    parameter int VRES        = 720,
    parameter int KERNEL_SIZE = 3,
    parameter int RAM_LATENCY = 2
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic [$clog2(HRES)-1:0]          hcount_in,
    input  logic [$clog2(VRES)-1:0]          vcount_in,
    input  logic                             data_valid_in,
    output logic [KERNEL_SIZE:0]             we_out,
    output logic [$clog2(HRES)-1:0]          wr_addr_out,
    output logic [$clog2(HRES)-1:0]          rd_addr_out,
    output logic [$clog2(KERNEL_SIZE+1)-1:0] rd_sel_out,
    output logic                             window_valid_out,
    output logic [$clog2(HRES)-1:0]          hcount_out,
    output logic [$clog2(VRES)-1:0]          vcount_out,
    output logic                             flush_abort_out
);
    localparam int HW = $clog2(HRES);
    localparam int VW = $clog2(VRES);
    localparam int NB = KERNEL_SIZE + 1;
    localparam int SW = $clog2(NB);
    localparam logic [HW-1:0] LAST_COL  = HW'(HRES - 1);
    localparam logic [VW-1:0] LAST_ROW  = VW'(VRES - 1);
    localparam logic [VW-1:0] HALF      = VW'(NB / 2);
    localparam logic [VW-1:0] FLUSH_ROW = VW'(VRES - NB / 2);
    localparam logic [SW-1:0] FULL      = SW'(KERNEL_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_FLUSH} state_t;

    state_t          r_state, w_next;
    logic [SW-1:0]   r_wp, w_wp_next;
    logic [SW-1:0]   r_lines, w_lines_next;
    logic [HW-1:0]   r_fcnt, w_fcnt_next;
    logic [1:0]      r_rst_sync;
    logic            w_rst_n;
    logic            w_frame_start, w_row_end, w_issue, w_abort;
    logic [NB-1:0]   w_we;
    logic [HW-1:0]   w_rd_addr;
    logic [VW-1:0]   w_tag_v;
    logic [SW-1:0]   w_sel_now;

    logic            r_pv [RAM_LATENCY];
    logic [HW-1:0]   r_ph [RAM_LATENCY];
    logic [VW-1:0]   r_pc [RAM_LATENCY];
    logic [SW-1:0]   r_ps [RAM_LATENCY];

    // Assert asynchronously, deassert after two clk_in edges.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_rst_sync <= '0;
        else           r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_frame_start = data_valid_in && (hcount_in == '0) && (vcount_in == '0);
    assign w_row_end     = data_valid_in && (hcount_in == LAST_COL);
    assign w_sel_now     = (r_wp == FULL) ? '0 : r_wp + 1'b1;

    always_comb begin
        w_next       = r_state;
        w_wp_next    = r_wp;
        w_lines_next = r_lines;
        w_fcnt_next  = r_fcnt;
        w_we         = '0;
        w_issue      = 1'b0;
        w_rd_addr    = '0;
        w_tag_v      = '0;
        w_abort      = 1'b0;
        if (w_frame_start) begin
            w_next       = S_FILL;
            w_wp_next    = '0;
            w_lines_next = '0;
            w_fcnt_next  = '0;
            w_we         = NB'(1);
            w_abort      = (r_state == S_FLUSH);
        end else begin
            case (r_state)
                S_FILL, S_STREAM: begin
                    if (data_valid_in) begin
                        w_we = NB'(1) << r_wp;
                        if (r_state == S_STREAM) begin
                            w_issue   = 1'b1;
                            w_rd_addr = hcount_in;
                            w_tag_v   = vcount_in - HALF;
                        end
                        if (w_row_end) begin
                            w_wp_next    = (r_wp == FULL) ? '0 : r_wp + 1'b1;
                            w_lines_next = (r_lines == FULL) ? r_lines : r_lines + 1'b1;
                            if (r_state == S_FILL && r_lines == FULL - 1'b1)
                                w_next = S_STREAM;
                            if (r_state == S_STREAM && vcount_in == LAST_ROW) begin
                                w_next      = S_FLUSH;
                                w_fcnt_next = '0;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    w_issue     = 1'b1;
                    w_rd_addr   = r_fcnt;
                    w_tag_v     = FLUSH_ROW;
                    w_fcnt_next = r_fcnt + 1'b1;
                    if (r_fcnt == LAST_COL) w_next = S_IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
            r_wp    <= '0;
            r_lines <= '0;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_next;
            r_wp    <= w_wp_next;
            r_lines <= w_lines_next;
            r_fcnt  <= w_fcnt_next;
        end
    end

    // Read tags ride alongside the BRAM read latency; the last stage drives the outputs.
    always_ff @(posedge clk_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_ph[i] <= '0;
                r_pc[i] <= '0;
                r_ps[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_issue;
            r_ph[0] <= w_rd_addr;
            r_pc[0] <= w_tag_v;
            r_ps[0] <= w_issue ? w_sel_now : '0;
            for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_ph[i] <= r_ph[i-1];
                r_pc[i] <= r_pc[i-1];
                r_ps[i] <= r_ps[i-1];
            end
        end
    end

    assign we_out           = w_rst_n ? w_we : '0;
    assign wr_addr_out      = hcount_in;
    assign rd_addr_out      = w_rst_n ? w_rd_addr : '0;
    assign flush_abort_out  = w_rst_n & w_abort;
    assign window_valid_out = r_pv[RAM_LATENCY-1];
    assign hcount_out       = r_ph[RAM_LATENCY-1];
    assign vcount_out       = r_pc[RAM_LATENCY-1];
    assign rd_sel_out       = r_ps[RAM_LATENCY-1];

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Randomized-gap raster bench for line_buffer_ctrl against a frame-level
// reference model (rows received, BRAM = row mod 4, delayed expected read tags).
module tb_line_buffer_ctrl;
    localparam int HRES = 8;
    localparam int VRES = 6;
    localparam int K    = 3;
    localparam int LAT  = 2;
    localparam int NB   = K + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] h_in = '0;
    logic [2:0] v_in = '0;
    logic       dv = 1'b0;
    logic [3:0] we_out;
    logic [2:0] wr_addr_out, rd_addr_out, hcount_out, vcount_out;
    logic [1:0] rd_sel_out;
    logic       window_valid_out, flush_abort_out;

    line_buffer_ctrl #(.HRES(HRES), .VRES(VRES), .KERNEL_SIZE(K), .RAM_LATENCY(LAT)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .hcount_in(h_in), .vcount_in(v_in),
        .data_valid_in(dv), .we_out(we_out), .wr_addr_out(wr_addr_out),
        .rd_addr_out(rd_addr_out), .rd_sel_out(rd_sel_out),
        .window_valid_out(window_valid_out), .hcount_out(hcount_out),
        .vcount_out(vcount_out), .flush_abort_out(flush_abort_out)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_FRAME, M_FLUSH} mmode_t;
    typedef struct { bit v; int h; int row; int sel; } tag_t;

    int     checks = 0;
    int     failures = 0;
    int     win_cnt = 0;
    int     abort_cnt = 0;
    mmode_t m_mode = M_IDLE;
    int     m_rows = 0;
    int     m_fidx = 0;
    tag_t   pipe [LAT];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pipe();
        for (int i = 0; i < LAT; i++) begin
            pipe[i].v = 1'b0; pipe[i].h = 0; pipe[i].row = 0; pipe[i].sel = 0;
        end
    endtask

    // One clock of stimulus plus checking against the frame-level model.
    task automatic step(input bit valid, input int h, input int v);
        tag_t t;
        int   exp_we;
        bit   exp_abort;
        @(negedge clk);
        dv = valid; h_in = 3'(h); v_in = 3'(v);
        #1;
        chk("window_valid", window_valid_out, pipe[LAT-1].v);
        if (pipe[LAT-1].v) begin
            chk("hcount_out", hcount_out, pipe[LAT-1].h);
            chk("vcount_out", vcount_out, pipe[LAT-1].row);
            chk("rd_sel_out", rd_sel_out, pipe[LAT-1].sel);
        end
        if (window_valid_out === 1'b1) win_cnt++;
        if (flush_abort_out === 1'b1) abort_cnt++;
        t.v = 1'b0; t.h = 0; t.row = 0; t.sel = 0;
        exp_we = 0; exp_abort = 1'b0;
        if (valid && h == 0 && v == 0) begin
            exp_abort = (m_mode == M_FLUSH);
            exp_we = 1;
            m_mode = M_FRAME;
            m_rows = 0;
        end else if (m_mode == M_FLUSH) begin
            t.v = 1'b1; t.h = m_fidx; t.row = VRES - NB / 2; t.sel = (m_rows - K) % NB;
            m_fidx++;
            if (m_fidx == HRES) m_mode = M_IDLE;
        end else if (m_mode == M_FRAME && valid) begin
            exp_we = 1 << (m_rows % NB);
            if (m_rows >= K) begin
                t.v = 1'b1; t.h = h; t.row = v - NB / 2; t.sel = (m_rows - K) % NB;
            end
            if (h == HRES - 1) begin
                if (m_rows >= K && v == VRES - 1) begin
                    m_mode = M_FLUSH;
                    m_fidx = 0;
                end
                m_rows++;
            end
        end
        chk("we_out", we_out, exp_we);
        if (exp_we != 0) chk("wr_addr_out", wr_addr_out, h);
        chk("flush_abort_out", flush_abort_out, exp_abort);
        if (t.v) chk("rd_addr_out", rd_addr_out, t.h);
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = t;
    endtask

    task automatic row_span(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) begin
            if ($urandom_range(0, 3) == 0)
                step(1'b0, $urandom_range(0, HRES - 1), $urandom_range(0, VRES - 1));
            step(1'b1, h, v);
        end
    endtask

    task automatic rows(input int r0, input int r1);
        for (int r = r0; r <= r1; r++) row_span(r, 0, HRES - 1);
    endtask

    // Idle/flush cycles, optionally with valid pixels that are never a frame start.
    task automatic idle(input int n, input bit junk);
        for (int i = 0; i < n; i++) begin
            if (junk && $urandom_range(0, 1) == 1)
                step(1'b1, $urandom_range(1, HRES - 1), $urandom_range(0, VRES - 1));
            else
                step(1'b0, 0, 0);
        end
    endtask

    task automatic check_reset_outputs(input string where);
        chk({where, "_we"}, we_out, 0);
        chk({where, "_rd_addr"}, rd_addr_out, 0);
        chk({where, "_rd_sel"}, rd_sel_out, 0);
        chk({where, "_wvalid"}, window_valid_out, 0);
        chk({where, "_hout"}, hcount_out, 0);
        chk({where, "_vout"}, vcount_out, 0);
        chk({where, "_abort"}, flush_abort_out, 0);
    endtask

    task automatic do_reset(input string where);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(where);
        m_mode = M_IDLE; m_rows = 0; m_fidx = 0;
        clear_pipe();
        @(negedge clk);
        dv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    int w0, w1, a0;

    initial begin
        clear_pipe();
        // Frame-start pattern held on the inputs throughout reset must stay invisible.
        dv = 1'b1; h_in = '0; v_in = '0;
        #12 check_reset_outputs("por");
        @(negedge clk);
        dv = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // IDLE ignores non-frame-start pixels, including row ends.
        step(1'b1, 3, 2);
        step(1'b1, HRES - 1, 1);
        step(1'b1, HRES - 1, VRES - 1);
        step(1'b0, 0, 0);

        // Frame A: complete raster with flush.
        w0 = win_cnt;
        rows(0, VRES - 1);
        idle(12, 1'b1);
        chk("frameA_windows", win_cnt - w0, (VRES - K + 1) * HRES);
        step(1'b1, 3, 3);

        // Frame B aborted by a frame start on the 3rd flush cycle.
        w0 = win_cnt; a0 = abort_cnt;
        rows(0, VRES - 1);
        step(1'b0, 0, 0);
        step(1'b0, 0, 0);
        step(1'b1, 0, 0);
        row_span(0, 1, HRES - 1);
        chk("abort_windows", win_cnt - w0, (VRES - K) * HRES + 2);
        chk("abort_pulses", abort_cnt - a0, 1);

        // Frame C cut mid-row 4 by a resync frame start (frame D).
        rows(1, 3);
        row_span(4, 0, 3);
        step(1'b0, 0, 0);
        step(1'b0, 0, 0);
        w1 = win_cnt; a0 = abort_cnt;
        step(1'b1, 0, 0);
        row_span(0, 1, HRES - 1);
        rows(1, K - 1);
        chk("resync_quiet", win_cnt - w1, 0);
        chk("resync_no_abort", abort_cnt - a0, 0);
        rows(K, VRES - 1);
        idle(12, 1'b1);
        chk("frameD_windows", win_cnt - w1, (VRES - K + 1) * HRES);

        // Reset mid-STREAM discards in-flight reads.
        rows(0, K - 1);
        row_span(K, 0, 4);
        do_reset("rst_stream");
        w0 = win_cnt;
        idle(6, 1'b1);
        chk("rst_stream_quiet", win_cnt - w0, 0);

        // Reset mid-FLUSH.
        step(1'b1, 0, 0);
        row_span(0, 1, HRES - 1);
        rows(1, VRES - 1);
        step(1'b0, 0, 0);
        step(1'b0, 0, 0);
        do_reset("rst_flush");
        w0 = win_cnt;
        idle(6, 1'b1);
        chk("rst_flush_quiet", win_cnt - w0, 0);

        // Reset mid-FILL, then a short frame resumes normally.
        step(1'b1, 0, 0);
        row_span(0, 1, 5);
        do_reset("rst_fill");
        step(1'b1, 5, 5);
        w0 = win_cnt;
        step(1'b1, 0, 0);
        row_span(0, 1, HRES - 1);
        rows(1, VRES - 1);
        idle(12, 1'b0);
        chk("frameF_windows", win_cnt - w0, (VRES - K + 1) * HRES);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
